// File: rtl/parking_occupancy_ctrl.sv
// rtl/parking_occupancy_ctrl.sv - dual-gate parking occupancy controller
// Tracks university/guest counts against fixed and hour-scheduled guest capacity.
module parking_occupancy_ctrl #(
  parameter int CNT_W         = 10,
  parameter int TOTAL_CAP     = 700,
  parameter int UNI_CAP       = 500,
  parameter int OPEN_HOUR     = 8,
  parameter int RAMP_START    = 13,
  parameter int RAMP_END      = 16,
  parameter int RAMP_STEP     = 50,
  parameter int GUEST_CAP_END = 500,
  parameter int GATE_HOLD     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       hour,
  input  logic             ent_req,
  input  logic             ent_is_uni,
  output logic             ent_ack,
  output logic             ent_deny,
  output logic             gate_open,
  input  logic             ext_req,
  input  logic             ext_is_uni,
  output logic             ext_ack,
  output logic             ext_err,
  output logic [CNT_W-1:0] uni_count,
  output logic [CNT_W-1:0] guest_count,
  output logic [CNT_W-1:0] guest_cap,
  output logic [CNT_W-1:0] uni_free,
  output logic [CNT_W-1:0] guest_free,
  output logic             uni_avail,
  output logic             guest_avail
);

  localparam int AW     = CNT_W + 5;
  localparam int HOLD_W = $clog2(GATE_HOLD + 1);

  typedef enum logic {E_IDLE, E_OPEN} ent_state_e;

  ent_state_e        state_q;
  logic [HOLD_W-1:0] hold_q;
  logic [CNT_W-1:0]  uni_q, uni_d, guest_q, guest_d, cap_q;
  logic              ent_ack_q, ent_deny_q, gate_open_q, ext_ack_q, ext_err_q;

  logic [AW-1:0]     hour_x, ramp_val, cap_d;
  logic [CNT_W:0]    occ;
  logic [CNT_W-1:0]  total_free, uni_room, guest_room, uni_free_c, guest_free_c;
  logic              open_win, ent_accept, ent_refuse, ext_ok, ext_bad;

  // Guest capacity schedule; ramp arithmetic is widened so the clamp sees true values.
  always_comb begin
    hour_x   = AW'(hour);
    ramp_val = AW'(TOTAL_CAP - UNI_CAP) + (hour_x - AW'(RAMP_START)) * AW'(RAMP_STEP);
    cap_d    = AW'(TOTAL_CAP - UNI_CAP);
    if (hour_x >= AW'(OPEN_HOUR) && hour < 5'd24 && hour_x >= AW'(RAMP_START)) begin
      if (hour_x < AW'(RAMP_END))
        cap_d = (ramp_val > AW'(GUEST_CAP_END)) ? AW'(GUEST_CAP_END) : ramp_val;
      else
        cap_d = AW'(GUEST_CAP_END);
    end
  end

  always_comb begin
    occ          = {1'b0, uni_q} + {1'b0, guest_q};
    total_free   = (occ >= (CNT_W+1)'(TOTAL_CAP)) ? '0 : CNT_W'((CNT_W+1)'(TOTAL_CAP) - occ);
    uni_room     = (uni_q >= CNT_W'(UNI_CAP)) ? '0 : CNT_W'(UNI_CAP) - uni_q;
    guest_room   = (guest_q >= cap_q) ? '0 : cap_q - guest_q;
    uni_free_c   = (uni_room < total_free) ? uni_room : total_free;
    guest_free_c = (guest_room < total_free) ? guest_room : total_free;
  end

  // Entry decision uses pre-edge counts, so a same-cycle exit never makes room.
  always_comb begin
    open_win   = (hour >= 5'(OPEN_HOUR)) && (hour < 5'd24);
    ent_accept = (state_q == E_IDLE) && ent_req && open_win &&
                 (ent_is_uni ? (uni_free_c != '0) : (guest_free_c != '0));
    ent_refuse = (state_q == E_IDLE) && ent_req && !ent_accept;
    ext_ok     = ext_req && (ext_is_uni ? (uni_q != '0) : (guest_q != '0));
    ext_bad    = ext_req && !ext_ok;
    uni_d      = uni_q + CNT_W'(ent_accept && ent_is_uni) - CNT_W'(ext_ok && ext_is_uni);
    guest_d    = guest_q + CNT_W'(ent_accept && !ent_is_uni) - CNT_W'(ext_ok && !ext_is_uni);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= E_IDLE;
      hold_q      <= '0;
      uni_q       <= '0;
      guest_q     <= '0;
      cap_q       <= CNT_W'(TOTAL_CAP - UNI_CAP);
      ent_ack_q   <= 1'b0;
      ent_deny_q  <= 1'b0;
      gate_open_q <= 1'b0;
      ext_ack_q   <= 1'b0;
      ext_err_q   <= 1'b0;
    end else begin
      uni_q      <= uni_d;
      guest_q    <= guest_d;
      cap_q      <= CNT_W'(cap_d);
      ent_ack_q  <= ent_accept;
      ent_deny_q <= ent_refuse;
      ext_ack_q  <= ext_ok;
      ext_err_q  <= ext_bad;
      case (state_q)
        E_IDLE: begin
          if (ent_accept) begin
            state_q     <= E_OPEN;
            hold_q      <= HOLD_W'(GATE_HOLD);
            gate_open_q <= 1'b1;
          end
        end
        E_OPEN: begin
          if (hold_q == '0) begin
            state_q     <= E_IDLE;
            gate_open_q <= 1'b0;
          end else begin
            hold_q <= hold_q - 1'b1;
          end
        end
        default: begin
          state_q     <= E_IDLE;
          gate_open_q <= 1'b0;
        end
      endcase
    end
  end

  assign ent_ack     = ent_ack_q;
  assign ent_deny    = ent_deny_q;
  assign gate_open   = gate_open_q;
  assign ext_ack     = ext_ack_q;
  assign ext_err     = ext_err_q;
  assign uni_count   = uni_q;
  assign guest_count = guest_q;
  assign guest_cap   = cap_q;
  assign uni_free    = uni_free_c;
  assign guest_free  = guest_free_c;
  assign uni_avail   = (uni_free_c != '0);
  assign guest_avail = (guest_free_c != '0);

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// tb/tb_parking_occupancy_ctrl.sv - random + directed bench against an occupancy reference model
module tb_parking_occupancy_ctrl;

  localparam int CNT_W = 10, TOTAL = 700, UNI = 500, OPEN_H = 8, R_START = 13,
                 R_END = 16, R_STEP = 50, G_END = 500, HOLD = 4;
  localparam int BASE = TOTAL - UNI;

  logic             clk = 1'b0;
  logic             reset, ent_req, ent_is_uni, ext_req, ext_is_uni;
  logic [4:0]       hour;
  logic             ent_ack, ent_deny, gate_open, ext_ack, ext_err, uni_avail, guest_avail;
  logic [CNT_W-1:0] uni_count, guest_count, guest_cap, uni_free, guest_free;

  parking_occupancy_ctrl #(
    .CNT_W(CNT_W), .TOTAL_CAP(TOTAL), .UNI_CAP(UNI), .OPEN_HOUR(OPEN_H),
    .RAMP_START(R_START), .RAMP_END(R_END), .RAMP_STEP(R_STEP),
    .GUEST_CAP_END(G_END), .GATE_HOLD(HOLD)
  ) dut (
    .clk(clk), .reset(reset), .hour(hour),
    .ent_req(ent_req), .ent_is_uni(ent_is_uni), .ent_ack(ent_ack), .ent_deny(ent_deny),
    .gate_open(gate_open), .ext_req(ext_req), .ext_is_uni(ext_is_uni),
    .ext_ack(ext_ack), .ext_err(ext_err), .uni_count(uni_count), .guest_count(guest_count),
    .guest_cap(guest_cap), .uni_free(uni_free), .guest_free(guest_free),
    .uni_avail(uni_avail), .guest_avail(guest_avail)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: occupancy numbers and remaining cycles the gate stays open.
  int m_uni, m_guest, m_cap, m_left;
  int e_ent_ack, e_ent_deny, e_ext_ack, e_ext_err;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat0(input int v);
    return (v < 0) ? 0 : v;
  endfunction

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int cap_for(input int h);
    if (h < OPEN_H || h >= 24 || h < R_START) return BASE;
    if (h < R_END) return min2(BASE + (h - R_START) * R_STEP, G_END);
    return G_END;
  endfunction

  function automatic int free_of(input bit uni_cls, input int u, input int g, input int cap);
    int tf;
    tf = sat0(TOTAL - (u + g));
    return uni_cls ? min2(sat0(UNI - u), tf) : min2(sat0(cap - g), tf);
  endfunction

  task automatic step();
    int uf, gf, du, dg;
    e_ent_ack = 0; e_ent_deny = 0; e_ext_ack = 0; e_ext_err = 0;
    if (reset) begin
      m_uni = 0; m_guest = 0; m_cap = BASE; m_left = 0;
    end else begin
      uf = free_of(1'b1, m_uni, m_guest, m_cap);
      gf = free_of(1'b0, m_uni, m_guest, m_cap);
      du = 0; dg = 0;
      if (m_left > 0) begin
        m_left--;
      end else if (ent_req) begin
        if (hour >= OPEN_H && hour < 24 && (ent_is_uni ? uf : gf) > 0) begin
          e_ent_ack = 1;
          m_left = HOLD + 1;
          if (ent_is_uni) du++; else dg++;
        end else begin
          e_ent_deny = 1;
        end
      end
      if (ext_req) begin
        if ((ext_is_uni ? m_uni : m_guest) > 0) begin
          e_ext_ack = 1;
          if (ext_is_uni) du--; else dg--;
        end else begin
          e_ext_err = 1;
        end
      end
      m_uni += du;
      m_guest += dg;
      m_cap = cap_for(int'(hour));
    end
    @(posedge clk);
    #1;
    uf = free_of(1'b1, m_uni, m_guest, m_cap);
    gf = free_of(1'b0, m_uni, m_guest, m_cap);
    check_eq("ent_ack", int'(ent_ack), e_ent_ack);
    check_eq("ent_deny", int'(ent_deny), e_ent_deny);
    check_eq("ext_ack", int'(ext_ack), e_ext_ack);
    check_eq("ext_err", int'(ext_err), e_ext_err);
    check_eq("gate_open", int'(gate_open), int'(m_left > 0));
    check_eq("uni_count", int'(uni_count), m_uni);
    check_eq("guest_count", int'(guest_count), m_guest);
    check_eq("guest_cap", int'(guest_cap), m_cap);
    check_eq("uni_free", int'(uni_free), uf);
    check_eq("guest_free", int'(guest_free), gf);
    check_eq("uni_avail", int'(uni_avail), int'(uf > 0));
    check_eq("guest_avail", int'(guest_avail), int'(gf > 0));
  endtask

  task automatic do_reset();
    reset = 1'b1; ent_req = 1'b0; ext_req = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int opened;
    reset = 1'b1; hour = 5'd9; ent_req = 1'b0; ent_is_uni = 1'b0;
    ext_req = 1'b0; ext_is_uni = 1'b0;

    do_reset();
    check_eq("rst_cap", int'(guest_cap), 200);
    check_eq("rst_gate", int'(gate_open), 0);

    // Uni accept, then held request during gate_open is ignored.
    ent_req = 1'b1; ent_is_uni = 1'b1;
    step();
    check_eq("first_ack", int'(ent_ack), 1);
    check_eq("first_uni", int'(uni_count), 1);
    opened = int'(gate_open);
    for (int i = 0; i < 5; i++) begin
      step();
      opened += int'(gate_open);
      check_eq("hold_quiet", int'(ent_ack | ent_deny), 0);
    end
    check_eq("gate_cycles", opened, 5);
    step();
    check_eq("reaccept", int'(ent_ack), 1);
    ent_req = 1'b0;
    steps(6);

    // Closed hour and guest ramp.
    hour = 5'd7; ent_req = 1'b1; ent_is_uni = 1'b0;
    step();
    check_eq("closed_deny", int'(ent_deny), 1);
    ent_req = 1'b0;
    hour = 5'd14; step();
    check_eq("cap_14", int'(guest_cap), 250);
    hour = 5'd16; step();
    check_eq("cap_16", int'(guest_cap), 500);
    hour = 5'd25; step();
    check_eq("cap_25", int'(guest_cap), 200);

    // Guest fill at hour 9, then ramp opens room.
    do_reset();
    hour = 5'd9; ent_req = 1'b1; ent_is_uni = 1'b0;
    steps(6 * 200);
    step();
    check_eq("guest_full_cnt", int'(guest_count), 200);
    check_eq("guest_full_deny", int'(ent_deny), 1);
    check_eq("guest_full_avail", int'(guest_avail), 0);
    hour = 5'd14;
    steps(2);
    check_eq("ramp_accept", int'(ent_ack), 1);
    ent_req = 1'b0; steps(6);

    // Whole lot full.
    do_reset();
    hour = 5'd9; ent_req = 1'b1; ent_is_uni = 1'b1;
    steps(6 * 500);
    ent_is_uni = 1'b0;
    steps(6 * 200);
    hour = 5'd16;
    steps(2);
    check_eq("lot_uni", int'(uni_count), 500);
    check_eq("lot_guest_free", int'(guest_free), 0);
    check_eq("lot_deny", int'(ent_deny), 1);
    ent_req = 1'b0; steps(6);

    // Same-cycle guest entry and exit; exit on an empty class.
    do_reset();
    hour = 5'd9; ent_req = 1'b1; ent_is_uni = 1'b0;
    steps(6 * 10);
    ext_req = 1'b1; ext_is_uni = 1'b0;
    step();
    check_eq("sim_ent", int'(ent_ack), 1);
    check_eq("sim_ext", int'(ext_ack), 1);
    check_eq("sim_cnt", int'(guest_count), 10);
    ent_req = 1'b0; ext_is_uni = 1'b1;
    step();
    check_eq("ext_err", int'(ext_err), 1);
    ext_req = 1'b0;

    // Reset while the gate is open.
    steps(6);
    ent_req = 1'b1; ent_is_uni = 1'b1;
    steps(3);
    do_reset();
    check_eq("rst_open_gate", int'(gate_open), 0);
    check_eq("rst_open_cnt", int'(uni_count) + int'(guest_count), 0);
    ent_req = 1'b1;
    step();
    check_eq("post_rst_ack", int'(ent_ack), 1);

    // Randomized traffic.
    for (int i = 0; i < 6000; i++) begin
      if (i % 25 == 0)
        hour = ($urandom % 8 == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 23));
      reset      = ($urandom % 700 == 0);
      ent_req    = ($urandom % 4 != 0);
      ent_is_uni = $urandom % 2;
      ext_req    = ($urandom % 3 == 0);
      ext_is_uni = $urandom % 2;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
